// File: rtl/regfile_flags_if.sv
// regfile_flags_if: operand/status bus between the execute stage and the
// register file / flag block.
//   master : execute-stage side; drives addresses, write data, ALU status
//   slave  : regfile_flags side; returns read data and registered flags
// Signals:
//   SrcReg1/SrcReg2 read addresses, SrcData1/SrcData2 read data
//   DstReg/WriteReg/DstData write port
//   ALU_Result/ALU_Ovfl/FlagWrite flag-update inputs, Flags registered Z/V/N
interface regfile_flags_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] SrcReg1;
    logic [ADDR_W-1:0] SrcReg2;
    logic [ADDR_W-1:0] DstReg;
    logic              WriteReg;
    logic [DATA_W-1:0] DstData;
    logic [DATA_W-1:0] SrcData1;
    logic [DATA_W-1:0] SrcData2;
    logic [DATA_W-1:0] ALU_Result;
    logic              ALU_Ovfl;
    logic [2:0]        FlagWrite;
    logic [2:0]        Flags;

    modport master (
        output SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
               ALU_Result, ALU_Ovfl, FlagWrite,
        input  SrcData1, SrcData2, Flags
    );

    modport slave (
        input  SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
               ALU_Result, ALU_Ovfl, FlagWrite,
        output SrcData1, SrcData2, Flags
    );
endinterface

// File: rtl/regfile_flags.sv
// regfile_flags: 2**ADDR_W x DATA_W general-purpose register file with two
// combinational read ports and one write port, plus the Z/V/N flag register
// loaded from the execute-stage result.
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset, clears registers and flags
//   bus  - regfile_flags_if.slave (read/write ports, ALU status, Flags)
// Register 0 reads as zero and ignores writes.
// Optional build macro: REGFILE_BYPASS_EN - when defined, a read port that
// addresses the register being written this cycle returns DstData directly.
module regfile_flags #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    regfile_flags_if.slave bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        flags_q;
    logic [2:0]        flags_next;
    logic              wr_en;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Writes to R0 are dropped here, so regs[0] stays at its reset value.
    assign wr_en = bus.WriteReg && (bus.DstReg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.DstReg] <= bus.DstData;
        end
    end

    always_comb begin
        rd1 = (bus.SrcReg1 == '0) ? '0 : regs[bus.SrcReg1];
        rd2 = (bus.SrcReg2 == '0) ? '0 : regs[bus.SrcReg2];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes R0, so R0 is never bypassed.
        if (wr_en && (bus.SrcReg1 == bus.DstReg)) rd1 = bus.DstData;
        if (wr_en && (bus.SrcReg2 == bus.DstReg)) rd2 = bus.DstData;
`endif
    end

    assign bus.SrcData1 = rd1;
    assign bus.SrcData2 = rd2;

    // Bit order: [2]=Z, [1]=V, [0]=N.
    always_comb begin
        flags_next[2] = (bus.ALU_Result == '0);
        flags_next[1] = bus.ALU_Ovfl;
        flags_next[0] = bus.ALU_Result[DATA_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else begin
            for (int unsigned b = 0; b < 3; b++) begin
                if (bus.FlagWrite[b]) flags_q[b] <= flags_next[b];
            end
        end
    end

    assign bus.Flags = flags_q;
endmodule

// File: tb/tb_regfile_flags.sv
// tb_regfile_flags: directed self-checking bench for regfile_flags.
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is sampled.
module tb_regfile_flags;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;

    regfile_flags_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_flags #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    task automatic push(input string tag, input logic [15:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow: observed %h expected <queued value>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] last_r4;
    logic [15:0] rnd;

    initial begin
        rst            = 1'b1;
        bus.SrcReg1    = '0;
        bus.SrcReg2    = '0;
        bus.DstReg     = '0;
        bus.WriteReg   = 1'b0;
        bus.DstData    = '0;
        bus.ALU_Result = '0;
        bus.ALU_Ovfl   = 1'b0;
        bus.FlagWrite  = 3'b000;

        // Reset state
        #2;
        bus.SrcReg1 = 4'd5;
        push("reset_src1", 16'h0000);
        push("reset_flags", 16'h0000);
        #1;
        check(bus.SrcData1);
        check({13'd0, bus.Flags});
        @(negedge clk);
        rst = 1'b0;

        // Write R5, set flags, then reset mid-cycle
        bus.WriteReg   = 1'b1;
        bus.DstReg     = 4'd5;
        bus.DstData    = 16'h1234;
        bus.ALU_Result = 16'h0000;
        bus.ALU_Ovfl   = 1'b1;
        bus.FlagWrite  = 3'b111;
        step();
        bus.WriteReg  = 1'b0;
        bus.FlagWrite = 3'b000;
        push("r5_written", 16'h1234);
        push("flags_pre_reset", 16'h0006);
        #1;
        check(bus.SrcData1);
        check({13'd0, bus.Flags});
        rst = 1'b1;
        push("r5_async_reset", 16'h0000);
        push("flags_async_reset", 16'h0000);
        #1;
        check(bus.SrcData1);
        check({13'd0, bus.Flags});
        #1;
        rst = 1'b0;

        // Write to R0 is discarded
        @(negedge clk);
        bus.WriteReg = 1'b1;
        bus.DstReg   = 4'd0;
        bus.DstData  = 16'hFFFF;
        bus.SrcReg1  = 4'd0;
        bus.SrcReg2  = 4'd0;
        step();
        bus.WriteReg = 1'b0;
        push("r0_src1", 16'h0000);
        push("r0_src2", 16'h0000);
        #1;
        check(bus.SrcData1);
        check(bus.SrcData2);

        // R3 and R7 on successive edges
        @(negedge clk);
        bus.WriteReg = 1'b1;
        bus.DstReg   = 4'd3;
        bus.DstData  = 16'hA5A5;
        step();
        bus.DstReg   = 4'd7;
        bus.DstData  = 16'h5A5A;
        step();
        bus.WriteReg = 1'b0;
        bus.SrcReg1  = 4'd3;
        bus.SrcReg2  = 4'd7;
        push("r3_src1", 16'hA5A5);
        push("r7_src2", 16'h5A5A);
        #1;
        check(bus.SrcData1);
        check(bus.SrcData2);
        bus.SrcReg1 = 4'd7;
        push("r7_both_src1", 16'h5A5A);
        push("r7_both_src2", 16'h5A5A);
        #1;
        check(bus.SrcData1);
        check(bus.SrcData2);

        // Same-cycle read/write on R9
        @(negedge clk);
        bus.WriteReg = 1'b1;
        bus.DstReg   = 4'd9;
        bus.DstData  = 16'h0001;
        step();
        bus.DstData  = 16'h0002;
        bus.SrcReg1  = 4'd9;
        bus.SrcReg2  = 4'd3;
`ifdef REGFILE_BYPASS_EN
        push("r9_same_cycle", 16'h0002);
`else
        push("r9_same_cycle", 16'h0001);
`endif
        push("r3_no_bypass", 16'hA5A5);
        #1;
        check(bus.SrcData1);
        check(bus.SrcData2);
        step();
        bus.WriteReg = 1'b0;
        push("r9_after_edge", 16'h0002);
        #1;
        check(bus.SrcData1);

        // Flag updates with partial enables
        @(negedge clk);
        bus.ALU_Result = 16'h0000;
        bus.ALU_Ovfl   = 1'b1;
        bus.FlagWrite  = 3'b111;
        step();
        push("flags_all", 16'h0006);
        check({13'd0, bus.Flags});
        bus.ALU_Result = 16'h8000;
        bus.ALU_Ovfl   = 1'b0;
        bus.FlagWrite  = 3'b001;
        step();
        push("flags_n_only", 16'h0007);
        check({13'd0, bus.Flags});
        bus.ALU_Result = 16'h0001;
        bus.ALU_Ovfl   = 1'b0;
        bus.FlagWrite  = 3'b010;
        step();
        push("flags_v_only", 16'h0005);
        check({13'd0, bus.Flags});
        bus.FlagWrite  = 3'b100;
        step();
        push("flags_z_only", 16'h0001);
        check({13'd0, bus.Flags});

        // FlagWrite=000 for 4 edges while writing R4
        bus.FlagWrite = 3'b000;
        bus.WriteReg  = 1'b1;
        bus.DstReg    = 4'd4;
        bus.SrcReg1   = 4'd4;
        for (int i = 0; i < 4; i++) begin
            rnd            = 16'($urandom);
            bus.ALU_Result = rnd;
            bus.ALU_Ovfl   = rnd[3];
            last_r4        = 16'($urandom);
            bus.DstData    = last_r4;
            step();
            push("hold_flags", 16'h0001);
            push("hold_r4", last_r4);
            check({13'd0, bus.Flags});
            check(bus.SrcData1);
        end

        // Register write and full flag update in the same cycle
        bus.DstData    = 16'hBEEF;
        bus.ALU_Result = 16'h8000;
        bus.ALU_Ovfl   = 1'b0;
        bus.FlagWrite  = 3'b111;
        step();
        bus.WriteReg  = 1'b0;
        bus.FlagWrite = 3'b000;
        push("simul_r4", 16'hBEEF);
        push("simul_flags", 16'h0001);
        check(bus.SrcData1);
        check({13'd0, bus.Flags});

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_flags.md
Name: regfile_flags

Overview:
- Operand source and status sink for the execute stage.
- Holds the 16-entry general-purpose register file that feeds the add/sub, parallel sub-word adder and shifter operand inputs.
- Also holds the architectural Z/V/N flag register, which latches status from the execute-stage result.
- Single clock domain; register writes and flag updates both occur on the rising edge.

Parameters:
- DATA_W, 16, register and result width in bits.
- ADDR_W, 4, register address width; number of registers = 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- SrcReg1  input  ADDR_W  read address, port 1.
- SrcReg2  input  ADDR_W  read address, port 2.
- DstReg  input  ADDR_W  write address.
- WriteReg  input  1  write enable for DstData into DstReg.
- DstData  input  DATA_W  write data.
- SrcData1  output  DATA_W  read data, port 1 (combinational).
- SrcData2  output  DATA_W  read data, port 2 (combinational).
- ALU_Result  input  DATA_W  execute-stage result used for flag generation.
- ALU_Ovfl  input  1  execute-stage overflow/error indication.
- FlagWrite  input  3  per-flag update enables: [2]=Z, [1]=V, [0]=N.
- Flags  output  3  registered flags: [2]=Z, [1]=V, [0]=N.

Behaviour:
- Reset: asynchronous, active-high. Clock is clk, reset is rst. Asserting rst immediately clears all registers to 0 and Flags to 3'b000, independent of clk. While rst is high, writes and flag updates are ignored. Deassertion takes effect at the next rising edge.
- Register 0 is hardwired to zero:
  - reads of address 0 always return 0;
  - writes to address 0 are discarded;
  - R0 is never bypassed.
- Reads: SrcData1/2 are combinational functions of SrcReg1/2 and array contents. There is no read latency; both ports are independent and may address the same register.
- Writes: on a rising edge with WriteReg=1 and DstReg!=0, reg[DstReg] <= DstData. The new value is visible on the read ports in the following cycle (see Optional Feature for same-cycle visibility).
- Flag generation, combinational from inputs:
  - Z_next = (ALU_Result == 0);
  - V_next = ALU_Ovfl;
  - N_next = ALU_Result[DATA_W-1].
- Flag update: on a rising edge, each Flags bit whose FlagWrite bit is 1 loads its *_next value; bits with FlagWrite=0 hold. Any mix of enables is legal, including 3'b000 (all hold) and 3'b111 (all update).
- Simultaneous events: a register write and a flag update in the same cycle are independent; both occur.
- Sustained WriteReg with a constant DstReg rewrites the register every edge, with the last value winning.
- Out-of-range addresses: none exist; ADDR_W fully decodes the array.
- Reset mid-operation: a write or flag update coinciding with rst is lost. Registers read 0 afterwards.
- Sizing: storage is 2**ADDR_W x DATA_W flops plus 3 flag flops; no latches.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a write-before-read bypass applies to each read port independently. When WriteReg=1, DstReg!=0 and SrcRegN==DstReg in the same cycle, SrcDataN = DstData combinationally.
- Not defined: SrcDataN returns the pre-write stored value until after the rising edge; no bypass logic is instantiated.

Test Plan:
- Assert rst mid-cycle after writing R5=16'h1234 -> SrcData1 (SrcReg1=5) reads 16'h0000 immediately, before any clk edge; Flags=3'b000.
- WriteReg=1, DstReg=0, DstData=16'hFFFF, one edge -> SrcData1 with SrcReg1=0 reads 16'h0000.
- Write R3=16'hA5A5 and R7=16'h5A5A on successive edges; SrcReg1=3, SrcReg2=7 -> SrcData1=16'hA5A5, SrcData2=16'h5A5A; SrcReg1=SrcReg2=7 -> both 16'h5A5A.
- Same-cycle read/write: R9 holds 16'h0001; WriteReg=1, DstReg=9, DstData=16'h0002, SrcReg1=9, checked before edge:
  - with REGFILE_BYPASS_EN -> 16'h0002;
  - without -> 16'h0001;
  - after edge -> 16'h0002 in both builds.
- ALU_Result=16'h0000, ALU_Ovfl=1, FlagWrite=3'b111, one edge -> Flags=3'b110. Then ALU_Result=16'h8000, ALU_Ovfl=0, FlagWrite=3'b001 -> Flags=3'b111 (Z, V held; N set).
- FlagWrite=3'b000 for 4 edges with random ALU_Result/ALU_Ovfl -> Flags unchanged. Same cycles with WriteReg=1 to R4 -> R4 updated, Flags unchanged.
